fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Sequences instruction fetch over a variable-latency instruction memory (req/ack), drives the PC's hold/pc_sel/next_pc.
//  Presents one fetched instruction at a time to the IF/ID register with a valid/stall handshake.
//  Applies branch/jump redirects, flushes wrong-path instructions, discards stale memory responses, flags memory timeouts.
// PARAMETERS
//  XLEN     32            data/address width
//  NOP      32'h00000013  instruction shown on if_instr when nothing valid (addi x0,x0,0)
//  TIMEOUT  255           max cycles a request may wait for ack before fetch_err; 1..2^TO_W-1
//  TO_W     8             watchdog counter width
// PORTS
//  clk             in   1     clock, rising edge
//  rst_n           in   1     asynchronous active-low reset
//  pc_in           in   XLEN  current PC from PC register
//  hold            out  1     1 = PC keeps value this cycle
//  pc_sel          out  1     0 = PC+4, 1 = load next_pc
//  next_pc         out  XLEN  redirect target to PC
//  imem_req        out  1     fetch request; held with stable imem_addr until imem_ack
//  imem_addr       out  XLEN  fetch address
//  imem_ack        in   1     response valid; may assert in the same cycle as imem_req
//  imem_rdata      in   32    instruction, valid with imem_ack
//  id_stall        in   1     decode cannot accept this cycle
//  redirect_valid  in   1     branch/jump taken, 1-cycle pulse
//  redirect_pc     in   XLEN  redirect target
//  if_valid        out  1     if_instr/if_pc hold a real instruction
//  if_instr        out  32    instruction to IF/ID
//  if_pc           out  XLEN  PC of if_instr
//  fetch_err       out  1     sticky: watchdog expired
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; if_valid=0, if_instr=NOP, if_pc=0, fetch_err=0, skid empty, wdog=0; imem_req=0, hold=1, pc_sel=0, next_pc=0.
//  Outputs: imem_req, imem_addr, hold, pc_sel, next_pc are combinational from state/inputs; all others registered.
//  buf_free = !if_valid | !id_stall (consumer takes the buffer at the edge when if_valid & !id_stall).
//  States:
//   IDLE  : req=0, hold=1; -> FETCH next cycle (first request 1 cycle after reset release).
//   FETCH : req=1, addr=pc_in, hold=1 until ack.
//           ack & buf_free  -> if_instr<=rdata, if_pc<=pc_in, if_valid<=1; hold=0 (PC+4); stay FETCH.
//           ack & !buf_free -> rdata/pc_in into skid reg; hold=0; -> SKID.
//           no ack, consumed buffer -> if_valid<=0.
//   SKID  : req=0, hold=1; when buf_free: buffer<=skid, if_valid<=1 -> FETCH.
//   KILL  : req=1, addr=kill_addr (address of abandoned request), hold=1 except on redirect; on ack drop rdata -> FETCH.
//  Redirect (priority over everything, any state except IDLE): hold=0, pc_sel=1, next_pc=redirect_pc;
//   if_valid<=0, if_instr<=NOP, skid emptied. From FETCH w/o ack -> KILL, kill_addr<=pc_in; FETCH w/ ack -> drop rdata, stay FETCH;
//   SKID -> FETCH; KILL -> stay KILL (kill_addr unchanged). Redirect in IDLE is ignored (PC not yet fetched).
//  Redirect and id_stall together: flush wins; buffer invalid next cycle regardless of stall.
//  Watchdog: wdog counts cycles with imem_req=1 & !imem_ack, clears on ack or req=0; wdog==TIMEOUT sets fetch_err (sticky until reset); fetch keeps waiting.
//  Throughput: zero-wait memory (ack with req) and no stall -> one instruction per cycle, PC advances every cycle.
//  Reset mid-request: all state cleared immediately; outstanding memory transaction is memory's responsibility.
// STRUCTURE
//  Shared package riscv_pkg: fetch state encoding (IDLE/FETCH/SKID/KILL), NOP constant, XLEN.
//  Sub-module fetch_watchdog (counter + sticky flag, params TIMEOUT/TO_W, in: clk,rst_n,waiting; out: expired).
//  Skid register and FSM stay in fetch_ctrl.
// TESTING
//  1 Zero-wait mem (ack=req), pc_in 0,4,8.. , no stall -> if_valid=1 from cycle 2, if_pc 0,4,8 consecutive, hold=0 each ack.
//  2 Ack latency 3 cycles -> req and imem_addr stable for 3 cycles, hold=1, if_valid=0 while buffer drained; one instr per 4 cycles.
//  3 id_stall=1 for 4 cycles with zero-wait mem -> if_instr frozen, one extra word into SKID, req=0; on release words delivered in order, none lost/duplicated.
//  4 redirect_pc=0x100 while request to 0x8 outstanding -> pc_sel=1,next_pc=0x100, KILL keeps addr 0x8 until ack, 0x8 data dropped, next if_pc=0x100.
//  5 Redirect in same cycle as ack and id_stall=1 -> if_valid=0 next cycle, if_instr=NOP, skid empty.
//  6 TIMEOUT=4, ack withheld -> fetch_err=1 after 4 waiting cycles, stays 1 after late ack; rst_n low clears it asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch constants and state encoding
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SKID  = 2'd2,
        ST_KILL  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - request wait counter with sticky expiry flag
module fetch_watchdog #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    output logic expired
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

    logic [TO_W-1:0] wdog;

    // Flag rises on the same edge the counter reaches LIMIT; counter saturates there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog    <= '0;
            expired <= 1'b0;
        end else begin
            if (!waiting) begin
                wdog <= '0;
            end else if (wdog != LIMIT) begin
                wdog <= wdog + TO_W'(1);
            end
            if (waiting && (wdog == LIMIT - TO_W'(1))) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer with skid buffer and redirect flush
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int          XLEN    = riscv_pkg::XLEN,
    parameter logic [31:0] NOP     = NOP_INSTR,
    parameter int          TIMEOUT = 255,
    parameter int          TO_W    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    output logic            hold,
    output logic            pc_sel,
    output logic [XLEN-1:0] next_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            id_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            fetch_err
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] kill_addr;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic            buf_free;
    logic            consumed;
    logic            redir;

    assign buf_free = !if_valid || !id_stall;
    assign consumed = if_valid && !id_stall;
    // Nothing has been fetched yet in IDLE, so a redirect there has nothing to flush.
    assign redir    = redirect_valid && (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        imem_addr = pc_in;
        hold      = 1'b1;
        pc_sel    = 1'b0;
        next_pc   = '0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    hold = 1'b0;
                    if (!redir && !buf_free) begin
                        state_nxt = ST_SKID;
                    end
                end else if (redir) begin
                    state_nxt = ST_KILL;
                end
            end
            ST_SKID: begin
                if (buf_free || redir) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_KILL: begin
                // Keep the abandoned address on the bus until memory answers it.
                imem_req  = 1'b1;
                imem_addr = kill_addr;
                if (imem_ack && !redir) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (redir) begin
            hold    = 1'b0;
            pc_sel  = 1'b1;
            next_pc = redirect_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid   <= 1'b0;
            if_instr   <= NOP;
            if_pc      <= '0;
            skid_instr <= NOP;
            skid_pc    <= '0;
            kill_addr  <= '0;
        end else if (redir) begin
            if_valid <= 1'b0;
            if_instr <= NOP;
            if ((state == ST_FETCH) && !imem_ack) begin
                kill_addr <= pc_in;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack && buf_free) begin
                        if_valid <= 1'b1;
                        if_instr <= imem_rdata;
                        if_pc    <= pc_in;
                    end else if (imem_ack) begin
                        skid_instr <= imem_rdata;
                        skid_pc    <= pc_in;
                    end else if (consumed) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP;
                    end
                end
                ST_SKID: begin
                    if (buf_free) begin
                        if_valid <= 1'b1;
                        if_instr <= skid_instr;
                        if_pc    <= skid_pc;
                    end
                end
                default: begin
                    if (consumed) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP;
                    end
                end
            endcase
        end
    end

    fetch_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (imem_req && !imem_ack),
        .expired (fetch_err)
    );

endmodule
